// File: rtl/tug_of_war_field.sv
// ---------------------------------------------------------------------------
// tug_of_war_field
//
// Two-player tug-of-war playfield. Each rising edge of a player's button
// pulls the lit position one step toward that player. Pulling past the
// player's own end of the field wins the round. After a round win the field
// goes dark for a short hold-off window. Once that window has expired, the
// next press starts a new round from the centre. When either score reaches
// its all-ones maximum, the match is over and the block freezes until reset.
//
// Parameters
//   NUM_LIGHTS  : number of playfield lights (odd, >= 3)
//   SCORE_W     : width of each player's round counter
//   HOLD_CYCLES : cycles after a round win during which presses are ignored
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high reset
//   L, R      : left / right player buttons (already synchronized levels)
//   lights    : playfield, bit NUM_LIGHTS-1 leftmost, bit 0 rightmost
//   winL/winR : left / right player won the current round
//   scoreL/R  : rounds won by each player
//   matchOver : a score reached 2^SCORE_W-1
// ---------------------------------------------------------------------------
module tug_of_war_field #(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  winL,
    output logic                  winR,
    output logic [SCORE_W-1:0]    scoreL,
    output logic [SCORE_W-1:0]    scoreR,
    output logic                  matchOver
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [PW-1:0]      CENTER    = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PW-1:0]      LEFT_END  = PW'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0] LAST_STEP = {{(SCORE_W-1){1'b1}}, 1'b0};
    localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic [HW-1:0] hold;
    logic          l_prev;
    logic          r_prev;
    logic          last_l;   // winner of the most recent round, shown in DONE

    logic press_l;
    logic press_r;

    assign press_l = L & ~l_prev;
    assign press_r = R & ~r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PLAY;
            pos    <= CENTER;
            scoreL <= '0;
            scoreR <= '0;
            hold   <= '0;
            // Treat buttons as already held so a press held through reset
            // must be released and pressed again before it counts.
            l_prev <= 1'b1;
            r_prev <= 1'b1;
            last_l <= 1'b0;
        end else begin
            l_prev <= L;
            r_prev <= R;
            case (state)
                PLAY: begin
                    if (press_l && !press_r) begin
                        if (pos != LEFT_END) begin
                            pos <= pos + 1'b1;
                        end else begin
                            last_l <= 1'b1;
                            scoreL <= scoreL + 1'b1;
                            hold   <= HOLD_LOAD;
                            // The winning increment that reaches the
                            // maximum ends the match instead of the round.
                            state  <= (scoreL == LAST_STEP) ? DONE : WIN_L;
                        end
                    end else if (press_r && !press_l) begin
                        if (pos != '0) begin
                            pos <= pos - 1'b1;
                        end else begin
                            last_l <= 1'b0;
                            scoreR <= scoreR + 1'b1;
                            hold   <= HOLD_LOAD;
                            state  <= (scoreR == LAST_STEP) ? DONE : WIN_R;
                        end
                    end
                end
                WIN_L, WIN_R: begin
                    if (hold != '0) begin
                        hold <= hold - 1'b1;
                    end else if (press_l || press_r) begin
                        // The restarting press only re-centres; it never moves.
                        state <= PLAY;
                        pos   <= CENTER;
                    end
                end
                DONE: begin
                    // Frozen until reset.
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state.
    always_comb begin
        lights    = (state == PLAY) ? (NUM_LIGHTS'(1) << pos) : '0;
        winL      = (state == WIN_L) || ((state == DONE) && last_l);
        winR      = (state == WIN_R) || ((state == DONE) && !last_l);
        matchOver = (state == DONE);
    end

endmodule

// File: tb/tb_tug_of_war_field.sv
// ---------------------------------------------------------------------------
// tb_tug_of_war_field
//
// Three instances share one clock:
//   A : default parameters (9 lights, 3-bit scores, hold 4)
//   B : 9 lights, 2-bit scores (match ends at 3 rounds)
//   C : 3 lights
// A game-level model per instance tracks every edge; a compare process
// checks all outputs against it on each falling edge. Directed scenarios
// add literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_tug_of_war_field;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rsta, la, ra;
    logic rstb, lb, rb;
    logic rstc, lc, rc;

    logic [8:0] lights_a;
    logic       winl_a, winr_a, mo_a;
    logic [2:0] scl_a, scr_a;

    logic [8:0] lights_b;
    logic       winl_b, winr_b, mo_b;
    logic [1:0] scl_b, scr_b;

    logic [2:0] lights_c;
    logic       winl_c, winr_c, mo_c;
    logic [2:0] scl_c, scr_c;

    tug_of_war_field #(.NUM_LIGHTS(9), .SCORE_W(3), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .reset(rsta), .L(la), .R(ra), .lights(lights_a),
        .winL(winl_a), .winR(winr_a), .scoreL(scl_a), .scoreR(scr_a),
        .matchOver(mo_a)
    );

    tug_of_war_field #(.NUM_LIGHTS(9), .SCORE_W(2), .HOLD_CYCLES(4)) dut_b (
        .clk(clk), .reset(rstb), .L(lb), .R(rb), .lights(lights_b),
        .winL(winl_b), .winR(winr_b), .scoreL(scl_b), .scoreR(scr_b),
        .matchOver(mo_b)
    );

    tug_of_war_field #(.NUM_LIGHTS(3), .SCORE_W(3), .HOLD_CYCLES(4)) dut_c (
        .clk(clk), .reset(rstc), .L(lc), .R(rc), .lights(lights_c),
        .winL(winl_c), .winR(winr_c), .scoreL(scl_c), .scoreR(scr_c),
        .matchOver(mo_c)
    );

    // Game model: phase 0 = playing, 1 = left won round, 2 = right won round,
    // 3 = match finished.
    typedef struct packed {
        int   phase;
        int   pos;
        int   sl;
        int   sr;
        int   wait_left;
        logic lheld;
        logic rheld;
        logic left_last;
    } game_t;

    game_t ma, mb, mc;

    function automatic game_t game_step(game_t g, logic rst, logic l, logic r,
                                        int n, int maxs, int hc);
        game_t o;
        logic  pl, pr;
        o = g;
        if (rst) begin
            o.phase = 0; o.pos = (n - 1) / 2; o.sl = 0; o.sr = 0;
            o.wait_left = 0; o.lheld = 1'b1; o.rheld = 1'b1; o.left_last = 1'b0;
            return o;
        end
        pl = l && !g.lheld;
        pr = r && !g.rheld;
        o.lheld = l;
        o.rheld = r;
        if (g.phase == 0) begin
            if (pl && !pr) begin
                if (g.pos < n - 1) o.pos = g.pos + 1;
                else begin
                    o.sl = g.sl + 1; o.left_last = 1'b1;
                    o.phase = (o.sl == maxs) ? 3 : 1; o.wait_left = hc;
                end
            end else if (pr && !pl) begin
                if (g.pos > 0) o.pos = g.pos - 1;
                else begin
                    o.sr = g.sr + 1; o.left_last = 1'b0;
                    o.phase = (o.sr == maxs) ? 3 : 2; o.wait_left = hc;
                end
            end
        end else if (g.phase == 1 || g.phase == 2) begin
            if (g.wait_left > 0) o.wait_left = g.wait_left - 1;
            else if (pl || pr) begin
                o.phase = 0; o.pos = (n - 1) / 2;
            end
        end
        return o;
    endfunction

    function automatic int exp_lights(game_t g);
        return (g.phase == 0) ? (1 << g.pos) : 0;
    endfunction

    function automatic int exp_flags(game_t g);
        logic wl, wr, mo;
        wl = (g.phase == 1) || (g.phase == 3 && g.left_last);
        wr = (g.phase == 2) || (g.phase == 3 && !g.left_last);
        mo = (g.phase == 3);
        return {29'd0, wl, wr, mo};
    endfunction

    always @(posedge clk) begin
        ma <= game_step(ma, rsta, la, ra, 9, 7, 4);
        mb <= game_step(mb, rstb, lb, rb, 9, 3, 4);
        mc <= game_step(mc, rstc, lc, rc, 3, 7, 4);
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("A.lights", 32'(lights_a), exp_lights(ma));
            check("A.flags",  {29'd0, winl_a, winr_a, mo_a}, exp_flags(ma));
            check("A.scoreL", 32'(scl_a), ma.sl);
            check("A.scoreR", 32'(scr_a), ma.sr);
            check("B.lights", 32'(lights_b), exp_lights(mb));
            check("B.flags",  {29'd0, winl_b, winr_b, mo_b}, exp_flags(mb));
            check("B.scoreL", 32'(scl_b), mb.sl);
            check("B.scoreR", 32'(scr_b), mb.sr);
            check("C.lights", 32'(lights_c), exp_lights(mc));
            check("C.flags",  {29'd0, winl_c, winr_c, mo_c}, exp_flags(mc));
            check("C.scoreL", 32'(scl_c), mc.sl);
            check("C.scoreR", 32'(scr_c), mc.sr);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic press_br();
        rb = 1'b1; cyc();
        rb = 1'b0; cyc();
    endtask

    task automatic press_bl();
        lb = 1'b1; cyc();
        lb = 1'b0; cyc();
    endtask

    initial begin
        rsta = 1'b1; la = 1'b0; ra = 1'b0;
        rstb = 1'b1; lb = 1'b0; rb = 1'b0;
        rstc = 1'b1; lc = 1'b0; rc = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b1;

        // Reset state of the default instance
        check("reset_lights", 32'(lights_a), 32'h010);
        check("reset_flags",  {29'd0, winl_a, winr_a, mo_a}, 32'd0);
        check("reset_scores", {26'd0, scl_a, scr_a}, 32'd0);
        rsta = 1'b0; rstb = 1'b0; rstc = 1'b0;
        cyc();

        // Four left presses walk the light to the left end
        for (int i = 0; i < 4; i++) begin
            la = 1'b1; cyc();
            check("walk_left", 32'(lights_a), 32'h010 << (i + 1));
            la = 1'b0; cyc();
        end
        check("model_pin_walk", exp_lights(ma), 32'h100);

        // Winning press from the left end, then the hold-off window
        la = 1'b1; cyc();
        check("winL_lights", 32'(lights_a), 32'h000);
        check("winL_flag",   32'(winl_a), 32'd1);
        check("winL_score",  32'(scl_a), 32'd1);
        la = 1'b0; cyc();
        la = 1'b1; cyc();
        check("hold_ignored_win",    32'(winl_a), 32'd1);
        check("hold_ignored_lights", 32'(lights_a), 32'h000);
        la = 1'b0; cyc();
        cyc();
        la = 1'b1; cyc();
        check("restart_lights", 32'(lights_a), 32'h010);
        check("restart_winL",   32'(winl_a), 32'd0);
        check("restart_score",  32'(scl_a), 32'd1);
        la = 1'b0; cyc();

        // Simultaneous press, then a long held press
        la = 1'b1; ra = 1'b1; cyc();
        check("simultaneous", 32'(lights_a), 32'h010);
        la = 1'b0; ra = 1'b0; cyc();
        la = 1'b1;
        repeat (10) cyc();
        check("held_one_step", 32'(lights_a), 32'h020);
        la = 1'b0; cyc();

        // Button held across reset deassertion
        la = 1'b1; rsta = 1'b1; cyc(); cyc();
        rsta = 1'b0; cyc(); cyc(); cyc();
        check("held_thru_reset", 32'(lights_a), 32'h010);
        check("held_thru_reset_score", 32'(scl_a), 32'd0);
        la = 1'b0; cyc();
        la = 1'b1; cyc();
        check("press_after_release", 32'(lights_a), 32'h020);
        la = 1'b0; cyc();

        // Two-bit scores: right wins three rounds and ends the match
        rstb = 1'b1; cyc(); rstb = 1'b0; cyc();
        for (int rnd = 0; rnd < 3; rnd++) begin
            if (rnd > 0) begin
                repeat (3) cyc();
                press_br();
            end
            repeat (5) press_br();
            check("B_round_score", 32'(scr_b), rnd + 1);
            check("B_round_winR",  32'(winr_b), 32'd1);
        end
        check("B_matchOver", 32'(mo_b), 32'd1);
        check("B_done_lights", 32'(lights_b), 32'h000);
        check("model_pin_done", exp_flags(mb), 32'b011);
        repeat (3) begin
            press_bl();
            press_br();
        end
        repeat (6) cyc();
        check("B_frozen_scores", {28'd0, scl_b, scr_b}, 32'b0011);
        check("B_frozen_flags",  {29'd0, winl_b, winr_b, mo_b}, 32'b011);
        rstb = 1'b1; cyc(); rstb = 1'b0;
        check("B_reset_score",  32'(scr_b), 32'd0);
        check("B_reset_lights", 32'(lights_b), 32'h010);
        check("B_reset_mo",     32'(mo_b), 32'd0);
        cyc();

        // Three-light field
        rstc = 1'b1; cyc(); rstc = 1'b0;
        check("C_reset_lights", 32'(lights_c), 32'b010);
        cyc();
        rc = 1'b1; cyc();
        check("C_first_R", 32'(lights_c), 32'b001);
        rc = 1'b0; cyc();
        rc = 1'b1; cyc();
        check("C_win_flag",   32'(winr_c), 32'd1);
        check("C_win_lights", 32'(lights_c), 32'b000);
        rc = 1'b0; cyc();

        // Randomized play on all three instances
        for (int k = 0; k < 4000; k++) begin
            la = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            lb = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            lc = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rsta = ($urandom_range(0, 299) == 0);
            rstb = ($urandom_range(0, 299) == 0);
            rstc = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rsta = 1'b0; rstb = 1'b0; rstc = 1'b0;
        la = 1'b0; ra = 1'b0; lb = 1'b0; rb = 1'b0; lc = 1'b0; rc = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
